// File: rtl/audio_uart_pkg.sv
// Shared types and constants for the audio sample UART framer.
// UART_FRAME_CHECKSUM_EN (when defined) adds the CHK state and a fourth checksum byte.
package audio_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_MSB,
    ST_LSB,
    ST_CHK
  } frame_state_e;

  localparam logic [4:0] SYNC_HI_DEFAULT    = 5'b10100;
  localparam int         FRAME_LEN_BASIC    = 3;
  localparam int         FRAME_LEN_CHECKSUM = 4;

  // The low three header bits carry the source channel so the receiver can demux.
  function automatic logic [7:0] make_header(input logic [4:0] sync_hi, input logic [2:0] ch);
    return {sync_hi, ch};
  endfunction

endpackage

// File: rtl/uart_frame_arbiter_rr.sv
// Round-robin grant: one-hot winner among requests, searching upward from ptr_i and wrapping.
module rr_arbiter
  import audio_uart_pkg::*;
#(
  parameter int P_NUM_CH = 4
) (
  input  logic [P_NUM_CH-1:0] req_i,
  input  logic [2:0]          ptr_i,
  output logic [P_NUM_CH-1:0] grant_o
);

  logic [3:0] idx;
  logic       found;

  // ptr_i is always below P_NUM_CH, so a single subtraction handles the wrap.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < P_NUM_CH; i++) begin
      idx = {1'b0, ptr_i} + 4'(i);
      if (idx >= 4'(P_NUM_CH)) idx = idx - 4'(P_NUM_CH);
      for (int j = 0; j < P_NUM_CH; j++) begin
        if (!found && req_i[j] && (idx == 4'(j))) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Arbitrates 16-bit samples from several channels into header/MSB/LSB byte frames for a UART.
// UART_FRAME_CHECKSUM_EN (when defined) appends an XOR checksum byte via the CHK state.
module uart_frame_arbiter
  import audio_uart_pkg::*;
#(
  parameter int         P_NUM_CH  = 4,
  parameter logic [4:0] P_SYNC_HI = SYNC_HI_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [16*P_NUM_CH-1:0]   i_ch_data,
  input  logic [P_NUM_CH-1:0]      i_ch_valid,
  output logic [P_NUM_CH-1:0]      o_ch_ready,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic [15:0]              o_frames
);

  frame_state_e        state_q;
  logic [2:0]          ptr_q;
  logic [2:0]          ptr_d;
  logic [2:0]          ch_q;
  logic [15:0]         sample_q;
  logic [15:0]         frames_q;
  logic                tx_valid_q;
  logic                busy_q;
  logic [P_NUM_CH-1:0] grant;
  logic [2:0]          grant_idx;
  logic [15:0]         grant_sample;
  logic                accept;
  logic                tx_fire;
  logic [7:0]          tx_data;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]          chk_q;
`endif

  rr_arbiter #(.P_NUM_CH(P_NUM_CH)) u_rr (
    .req_i   (i_ch_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    grant_idx    = '0;
    grant_sample = '0;
    for (int j = 0; j < P_NUM_CH; j++) begin
      if (grant[j]) begin
        grant_idx    = 3'(j);
        grant_sample = i_ch_data[16*j +: 16];
      end
    end
  end

  assign ptr_d = (grant_idx == 3'(P_NUM_CH - 1)) ? 3'd0 : grant_idx + 3'd1;

  // Ready is gated by reset too, so nothing can be accepted on a reset edge.
  assign o_ch_ready = (state_q == ST_IDLE && i_rst_n) ? grant : '0;
  assign accept     = |(o_ch_ready & i_ch_valid);
  assign tx_fire    = tx_valid_q & i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      ch_q       <= '0;
      sample_q   <= '0;
      frames_q   <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            sample_q   <= grant_sample;
            ch_q       <= grant_idx;
            ptr_q      <= ptr_d;
            state_q    <= ST_HDR;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q      <= make_header(P_SYNC_HI, grant_idx) ^ grant_sample[15:8] ^ grant_sample[7:0];
`endif
          end
        end
        ST_HDR: if (tx_fire) state_q <= ST_MSB;
        ST_MSB: if (tx_fire) state_q <= ST_LSB;
        ST_LSB: begin
          if (tx_fire) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_q    <= ST_CHK;
`else
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            frames_q   <= frames_q + 16'd1;
`endif
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        ST_CHK: begin
          if (tx_fire) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            frames_q   <= frames_q + 16'd1;
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Byte lane is decoded from registered state and fields, so it holds steady through a stall.
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      ST_HDR:  tx_data = make_header(P_SYNC_HI, ch_q);
      ST_MSB:  tx_data = sample_q[15:8];
      ST_LSB:  tx_data = sample_q[7:0];
`ifdef UART_FRAME_CHECKSUM_EN
      ST_CHK:  tx_data = chk_q;
`endif
      default: tx_data = 8'h00;
    endcase
  end

  assign o_tx_data  = tx_data;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_frames   = frames_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter; honours UART_FRAME_CHECKSUM_EN for the 4-byte frame.
module tb_uart_frame_arbiter;

  localparam int N = 4;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic [16*N-1:0] chData = '0;
  logic [N-1:0]    chValid = '0;
  logic            txReady = 1'b0;
  logic [N-1:0]    chReady;
  logic [7:0]      txData;
  logic            txValid;
  logic            busy;
  logic [15:0]     frames;

  always #5 clk = ~clk;

  uart_frame_arbiter #(.P_NUM_CH(N), .P_SYNC_HI(5'b10100)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_ch_data  (chData),
    .i_ch_valid (chValid),
    .o_ch_ready (chReady),
    .o_tx_data  (txData),
    .o_tx_valid (txValid),
    .i_tx_ready (txReady),
    .o_busy     (busy),
    .o_frames   (frames)
  );

  int         nChecks = 0;
  int         nPass = 0;
  logic [7:0] expQ[$];
  int         dutGrantLog[$];
  int         mPtr = 0;
  int         mRemain = 0;
  logic [15:0] mFrames = '0;
  bit         monEn = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Reference model: own round-robin pointer, pushes the expected frame bytes at each grant.
  logic [N-1:0] expGrant;
  int           g;
  int           dutIdx;
  logic [15:0]  d;
  logic [7:0]   hdr;
  logic [7:0]   exp8;
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("busy", 32'(busy), 32'(mRemain != 0));
      checkOutput("tx_valid", 32'(txValid), 32'(mRemain != 0));
      checkOutput("frames", 32'(frames), 32'(mFrames));
      if (mRemain == 0) begin
        expGrant = '0;
        g = -1;
        for (int i = 0; i < N; i++)
          if (g < 0 && chValid[(mPtr + i) % N]) g = (mPtr + i) % N;
        if (g >= 0) expGrant[g] = 1'b1;
        checkOutput("ch_ready", 32'(chReady), 32'(expGrant));
        dutIdx = -1;
        for (int i = 0; i < N; i++) if (chReady[i] && chValid[i]) dutIdx = i;
        if (dutIdx >= 0) dutGrantLog.push_back(dutIdx);
        if (g >= 0) begin
          d   = chData[16*g +: 16];
          hdr = {5'b10100, 3'(g)};
          expQ.push_back(hdr);
          expQ.push_back(d[15:8]);
          expQ.push_back(d[7:0]);
`ifdef UART_FRAME_CHECKSUM_EN
          expQ.push_back(hdr ^ d[15:8] ^ d[7:0]);
`endif
          mRemain = FRAME_LEN;
          mPtr    = (g + 1) % N;
        end
      end else begin
        checkOutput("ch_ready busy", 32'(chReady), 32'(0));
        if (txReady && expQ.size() > 0) begin
          exp8 = expQ.pop_front();
          checkOutput("tx_data", 32'(txData), 32'(exp8));
          mRemain--;
          if (mRemain == 0) mFrames++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input logic [N-1:0] validDuring);
    monEn   = 1'b0;
    rstN    = 1'b0;
    chValid = validDuring;
    tick(1);
    checkOutput("rst tx_valid", 32'(txValid), 32'(0));
    checkOutput("rst tx_data", 32'(txData), 32'(8'h00));
    checkOutput("rst ch_ready", 32'(chReady), 32'(0));
    checkOutput("rst busy", 32'(busy), 32'(0));
    checkOutput("rst frames", 32'(frames), 32'(0));
    expQ.delete();
    mRemain = 0;
    mPtr    = 0;
    mFrames = '0;
    chValid = '0;
    rstN    = 1'b1;
    monEn   = 1'b1;
  endtask

  // Raise valid on one channel and drop it right after the accepting edge.
  task automatic applyStimulus(input int ch, input logic [15:0] sample);
    bit granted;
    granted = 1'b0;
    chData[16*ch +: 16] = sample;
    chValid[ch] = 1'b1;
    for (int i = 0; i < 40 && !granted; i++) begin
      @(negedge clk);
      if (chReady[ch]) granted = 1'b1;
    end
    checkOutput("grant wait", 32'(granted), 32'(1));
    tick(1);
    chValid[ch] = 1'b0;
  endtask

  task automatic waitIdle(input bit randReady);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      tick(1);
      if (randReady) txReady = 1'($urandom_range(0, 1));
      if (mRemain == 0 && expQ.size() == 0) idle = 1'b1;
    end
    txReady = 1'b1;
    checkOutput("idle wait", 32'(idle), 32'(1));
  endtask

  int expOrder[5] = '{0, 1, 2, 3, 0};
  int base;
  bit done;

  initial begin
    applyReset(4'hF);

    // Single sample on ch2, ready held high: A2 12 34 back to back.
    txReady = 1'b1;
    applyStimulus(2, 16'h1234);
    waitIdle(1'b0);
    checkOutput("frames after ch2", 32'(frames), 32'(1));

    // All channels requesting from a fresh pointer.
    applyReset(4'h0);
    for (int k = 0; k < N; k++) chData[16*k +: 16] = 16'h1100 * 16'(k + 1);
    base    = dutGrantLog.size();
    chValid = 4'hF;
    done    = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick(1);
      if (dutGrantLog.size() >= base + 5) done = 1'b1;
    end
    chValid = '0;
    checkOutput("rr five grants", 32'(done), 32'(1));
    waitIdle(1'b0);
    for (int i = 0; i < 5; i++)
      if (dutGrantLog.size() > base + i)
        checkOutput($sformatf("rr order %0d", i), 32'(dutGrantLog[base + i]), 32'(expOrder[i]));

    // Long stall while the MSB byte is presented.
    txReady = 1'b0;
    applyStimulus(1, 16'hBEEF);
    checkOutput("hdr presented", 32'(txData), 32'(8'hA1));
    txReady = 1'b1;
    tick(1);
    txReady = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall data", 32'(txData), 32'(8'hBE));
      checkOutput("stall valid", 32'(txValid), 32'(1));
    end
    txReady = 1'b1;
    waitIdle(1'b0);

    // Reset while the LSB byte is on the lane abandons the frame.
    applyStimulus(0, 16'h5AC3);
    tick(2);
    checkOutput("in LSB", 32'(txData), 32'(8'hC3));
    applyReset(4'h0);
    base    = dutGrantLog.size();
    chValid = 4'b1001;
    done    = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(1);
      if (dutGrantLog.size() > base) done = 1'b1;
    end
    chValid = '0;
    checkOutput("post-reset grant seen", 32'(done), 32'(1));
    if (done) checkOutput("post-reset ptr", 32'(dutGrantLog[base]), 32'(0));
    waitIdle(1'b0);

    // Random samples with a jittery transmitter.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(int'($urandom_range(0, N - 1)), 16'($urandom));
      waitIdle(1'b1);
    end

    // Counter wrap from a preloaded value.
    force dut.frames_q = 16'hFFFE;
    mFrames = 16'hFFFE;
    tick(1);
    release dut.frames_q;
    applyStimulus(3, 16'h0F0F);
    waitIdle(1'b0);
    checkOutput("frames FFFF", 32'(frames), 32'(16'hFFFF));
    applyStimulus(1, 16'h7E81);
    waitIdle(1'b0);
    checkOutput("frames wrap", 32'(frames), 32'(16'h0000));

    monEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_frame_arbiter.md
UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

Interface
REQ-001 P_NUM_CH, 4, number of sample requesters; legal 2..8.
REQ-002 P_SYNC_HI, 5'b10100, upper 5 bits of every header byte.
REQ-003 i_clk  in  1  sole clock; all logic rising-edge.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_ch_data  in  16*P_NUM_CH  flattened samples; channel k at bits [16k+15:16k].
REQ-006 i_ch_valid  in  P_NUM_CH  per-channel sample valid.
REQ-007 o_ch_ready  out  P_NUM_CH  per-channel accept; at most one bit high.
REQ-008 o_tx_data  out  8  byte to the UART transmitter.
REQ-009 o_tx_valid  out  1  byte valid towards the transmitter.
REQ-010 i_tx_ready  in  1  transmitter can accept a byte.
REQ-011 o_busy  out  1  high whenever state is not IDLE.
REQ-012 o_frames  out  16  count of completed frames.

Function
REQ-013 Channel transfer SHALL occur on a cycle with i_ch_valid[k] and o_ch_ready[k] both high; TX transfer on o_tx_valid and i_tx_ready both high.
REQ-014 FSM states SHALL be IDLE, HDR, MSB, LSB, CHK; CHK exists only per REQ-026.
REQ-015 In IDLE, o_ch_ready SHALL be combinationally one-hot on the round-robin winner among asserted i_ch_valid bits, all-zero if none valid.
REQ-016 Round-robin search SHALL start at pointer p and wrap mod P_NUM_CH; after granting channel g, p SHALL become (g+1) mod P_NUM_CH.
REQ-017 On channel transfer the sample and channel index SHALL be registered and state SHALL go to HDR the next cycle.
REQ-018 Header byte SHALL be {P_SYNC_HI, ch[2:0]}; MSB state sends sample[15:8]; LSB state sends sample[7:0].
REQ-019 In HDR/MSB/LSB/CHK, o_tx_valid SHALL be high and o_tx_data stable until TX transfer; on transfer, advance to the next state in the same edge.
REQ-020 o_tx_valid SHALL be low in IDLE; first header byte appears exactly one cycle after channel transfer.
REQ-021 o_ch_ready SHALL be all-zero outside IDLE; new samples SHALL NOT be accepted mid-frame.
REQ-022 On the final byte's TX transfer, state SHALL return to IDLE and o_frames SHALL increment, wrapping 16'hFFFF -> 0.
REQ-023 i_tx_ready held low SHALL stall indefinitely with no byte loss or duplication.
REQ-024 i_ch_valid deasserting while not granted SHALL be ignored without error.

Reset
REQ-025 While i_rst_n is low at a clock edge: state IDLE, p = 0, o_tx_valid = 0, o_tx_data = 8'h00, o_ch_ready = 0, o_frames = 0, checksum = 0; a frame in progress SHALL be abandoned and no remaining bytes sent.

Configuration
REQ-026 With UART_FRAME_CHECKSUM_EN defined, LSB transfer SHALL go to CHK, which sends header ^ MSB ^ LSB, then IDLE (4-byte frame).
REQ-027 Without UART_FRAME_CHECKSUM_EN, LSB transfer SHALL go directly to IDLE (3-byte frame) and no checksum logic SHALL be synthesised.

Structure
REQ-028 Shared package audio_uart_pkg SHALL hold the FSM state type, default header constant 5'b10100, and frame-length constants (3 and 4).
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (request vector and pointer in, one-hot grant out).

Verification
REQ-030 Reset then ch2 valid with 16'h1234, i_tx_ready=1 -> bytes A2, 12, 34 on consecutive cycles; o_frames=1; with macro, fourth byte 84.
REQ-031 All 4 channels valid continuously, p=0 -> grant order 0,1,2,3,0; no channel starved.
REQ-032 i_tx_ready low 10 cycles during MSB of sample 16'hBEEF -> o_tx_data held at BE, o_tx_valid high, no extra byte after release.
REQ-033 i_rst_n low for 1 cycle during LSB state -> next cycle o_tx_valid=0, o_busy=0, o_frames=0, p=0.
REQ-034 o_frames preloaded via 65535 frames -> next frame completion wraps o_frames to 0.
